// File: rtl/isw_codec_pkg.sv
// Shared types and sizing helpers for the ISW share codec and its random-beat collector.
package isw_codec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam int GADGET_LAT = 3;

  function automatic int calc_n(input int d);
    return d + 1;
  endfunction

  function automatic int calc_r(input int d);
    return d * (d + 1) / 2;
  endfunction

  function automatic int calc_nr(input int d, input int rw);
    return 2 * d + calc_r(d) + 0 * rw;
  endfunction

  function automatic int calc_nb(input int d, input int rw);
    return (calc_nr(d, rw) + rw - 1) / rw;
  endfunction

endpackage

// File: rtl/isw_share_codec_if.sv
// Operand, random-source, gadget and result signals of the share codec.
interface isw_share_codec_if #(
  parameter int D  = 4,
  parameter int RW = 8
);
  import isw_codec_pkg::*;

  localparam int N = calc_n(D);
  localparam int R = calc_r(D);

  logic          in_valid;
  logic          in_ready;
  logic          in_a;
  logic          in_b;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [RW-1:0] rnd_data;
  logic [N-1:0]  port_a;
  logic [N-1:0]  port_b;
  logic [R-1:0]  port_r;
  logic [N-1:0]  port_c;
  logic          out_valid;
  logic          out_ready;
  logic          out_c;

  modport master (
    output in_valid, in_a, in_b, rnd_valid, rnd_data, port_c, out_ready,
    input  in_ready, rnd_ready, port_a, port_b, port_r, out_valid, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, rnd_valid, rnd_data, port_c, out_ready,
    output in_ready, rnd_ready, port_a, port_b, port_r, out_valid, out_c
  );

endinterface

// File: rtl/isw_share_codec_rnd_collector.sv
// Packs RW-bit random beats LSB-first into an NR-bit buffer; data/full include the beat accepted this cycle.
module rnd_collector #(
  parameter int NR = 18,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          accept,
  input  logic [RW-1:0] data_in,
  output logic [NR-1:0] data,
  output logic          full
);

  localparam int CW = $clog2(NR + RW + 1);

  logic [NR-1:0]    acc_q, acc_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [NR+RW-1:0] beat_ext;

  // Bits landing at or above NR fall off the truncation and are discarded.
  always_comb begin
    beat_ext = {{NR{1'b0}}, data_in} << cnt_q;
    acc_nxt  = acc_q;
    cnt_nxt  = cnt_q;
    if (accept) begin
      acc_nxt = acc_q | beat_ext[NR-1:0];
      cnt_nxt = cnt_q + CW'(RW);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign data = acc_nxt;
  assign full = (cnt_nxt >= CW'(NR));

endmodule

// File: rtl/isw_share_codec.sv
// Masks a/b into N Boolean shares for the ISW AND gadget and unmasks its output 3 cycles later.
// state   | meaning
// IDLE    | accept operand pair
// COLLECT | gather NR random bits from the source
// ISSUE   | shares and refresh bits presented to the gadget
// WAIT    | gadget pipeline in flight
// CAPTURE | recombine port_c, then clear shares
// DONE    | result held until consumed
module isw_share_codec
  import isw_codec_pkg::*;
#(
  parameter int D  = 4,
  parameter int RW = 8
) (
  input logic              clk,
  input logic              reset,
  isw_share_codec_if.slave bus
);

  localparam int N  = calc_n(D);
  localparam int R  = calc_r(D);
  localparam int NR = calc_nr(D, RW);

  state_t         state_q, state_nxt;
  logic           a_q, b_q, c_q;
  logic [1:0]     wait_q;
  logic [N-1:0]   pa_q, pb_q;
  logic [R-1:0]   pr_q;
  logic           col_clear, col_accept, col_full;
  logic [NR-1:0]  col_data;

  assign col_clear  = (state_q == ST_IDLE);
  assign col_accept = (state_q == ST_COLLECT) && bus.rnd_valid;

  rnd_collector #(.NR(NR), .RW(RW)) u_collector (
    .clk     (clk),
    .reset   (reset),
    .clear   (col_clear),
    .accept  (col_accept),
    .data_in (bus.rnd_data),
    .data    (col_data),
    .full    (col_full)
  );

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (bus.in_valid) state_nxt = ST_COLLECT;
      ST_COLLECT: if (col_full) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT:    if (wait_q == 2'd0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_DONE;
      ST_DONE:    if (bus.out_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      wait_q  <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      pr_q    <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == ST_IDLE && bus.in_valid) begin
        a_q <= bus.in_a;
        b_q <= bus.in_b;
      end
      // Share 0 absorbs the plain value so each operand's shares XOR back to it.
      if (state_q == ST_COLLECT && col_full) begin
        pa_q <= {col_data[D-1:0],   a_q ^ (^col_data[D-1:0])};
        pb_q <= {col_data[2*D-1:D], b_q ^ (^col_data[2*D-1:D])};
        pr_q <= col_data[NR-1:2*D];
      end
      if (state_q == ST_ISSUE)
        wait_q <= 2'(GADGET_LAT - 2);
      else if (state_q == ST_WAIT && wait_q != 2'd0)
        wait_q <= wait_q - 2'd1;
      if (state_q == ST_CAPTURE) begin
        c_q  <= ^bus.port_c;
        pa_q <= '0;
        pb_q <= '0;
        pr_q <= '0;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !reset;
  assign bus.rnd_ready = (state_q == ST_COLLECT);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_c     = c_q;
  assign bus.port_a    = pa_q;
  assign bus.port_b    = pb_q;
  assign bus.port_r    = pr_q;

endmodule

// File: tb/tb_isw_share_codec.sv
// Bench for isw_share_codec: ISW gadget model with 3-cycle latency, vector table, random ops, small-parameter instance.
module tb_isw_share_codec;
  import isw_codec_pkg::*;

  localparam int NB_A = calc_nb(4, 8);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  isw_share_codec_if #(.D(4), .RW(8)) ifa ();
  isw_share_codec_if #(.D(1), .RW(3)) ifs ();

  isw_share_codec #(.D(4), .RW(8)) u_dut   (.clk(clk), .reset(reset), .bus(ifa.slave));
  isw_share_codec #(.D(1), .RW(3)) u_small (.clk(clk), .reset(reset), .bus(ifs.slave));

  int n_pass = 0;
  int n_chk  = 0;
  int overlap = 0;

  // Textbook ISW multiplication over d+1 shares.
  function automatic logic [7:0] isw(input int d, input logic [7:0] a, input logic [7:0] b,
                                     input logic [15:0] r);
    logic [7:0] c;
    int k;
    logic z;
    c = a & b;
    k = 0;
    for (int i = 0; i <= d; i++)
      for (int j = i + 1; j <= d; j++) begin
        z    = r[k];
        c[i] = c[i] ^ z;
        c[j] = c[j] ^ ((z ^ (a[i] & b[j])) ^ (a[j] & b[i]));
        k++;
      end
    return c;
  endfunction

  logic [7:0] g1a, g2a, g1s, g2s;
  always @(posedge clk) begin
    if (reset) begin
      g1a <= '0; g2a <= '0; ifa.port_c <= '0;
      g1s <= '0; g2s <= '0; ifs.port_c <= '0;
    end else begin
      g1a <= isw(4, 8'(ifa.port_a), 8'(ifa.port_b), 16'(ifa.port_r));
      g2a <= g1a;
      ifa.port_c <= g2a[4:0];
      g1s <= isw(1, 8'(ifs.port_a), 8'(ifs.port_b), 16'(ifs.port_r));
      g2s <= g1s;
      ifs.port_c <= g2s[1:0];
    end
  end

  always @(negedge clk)
    if (!reset && ((ifa.in_ready && ifa.rnd_ready) || (ifs.in_ready && ifs.rnd_ready)))
      overlap++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Expected shares from the concatenated beat stream (beat 0 in the low byte).
  task automatic model(input logic a, input logic b, input logic [23:0] beats,
                       output logic [4:0] pa, output logic [4:0] pb, output logic [9:0] pr);
    logic [17:0] bits;
    bits = beats[17:0];
    pa = {bits[3:0], a ^ bits[0] ^ bits[1] ^ bits[2] ^ bits[3]};
    pb = {bits[7:4], b ^ bits[4] ^ bits[5] ^ bits[6] ^ bits[7]};
    pr = bits[17:8];
  endtask

  task automatic do_op(input logic a, input logic b, input logic [23:0] beats,
                       input logic [7:0] vpat, input int hold,
                       input logic [4:0] epa, input logic [4:0] epb, input logic [9:0] epr,
                       input logic ec);
    int cyc, k, got, c_last, t_issue;
    got = 0; c_last = 0;
    for (int i = 0; i < 64 && got < NB_A; i++)
      if (i >= 8 || vpat[i]) begin got++; c_last = i + 1; end
    t_issue = c_last + 1;
    check("in_ready_start", 32'(ifa.in_ready), 32'd1);
    ifa.in_valid = 1'b1; ifa.in_a = a; ifa.in_b = b;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    cyc = 1; k = 0;
    while (cyc < 60 && !ifa.out_valid) begin
      ifa.rnd_valid = (cyc > 8) ? 1'b1 : vpat[cyc-1];
      ifa.rnd_data  = (k < NB_A) ? beats[k*8 +: 8] : 8'h00;
      if (cyc == t_issue) begin
        check("issue_port_a", 32'(ifa.port_a), 32'(epa));
        check("issue_port_b", 32'(ifa.port_b), 32'(epb));
        check("issue_port_r", 32'(ifa.port_r), 32'(epr));
        check("issue_xor_a", 32'(^ifa.port_a), 32'(a));
      end
      if (ifa.rnd_valid && ifa.rnd_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    ifa.rnd_valid = 1'b0;
    check("latency", 32'(cyc), 32'(c_last + 5));
    check("beats_used", 32'(k), 32'(NB_A));
    check("out_c", 32'(ifa.out_c), 32'(ec));
    check("ports_cleared", 32'({ifa.port_a, ifa.port_b, ifa.port_r}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      ifa.in_valid = 1'b1; ifa.in_a = ~a; ifa.in_b = ~b;
      @(posedge clk); #1;
      check("hold_valid", 32'(ifa.out_valid), 32'd1);
      check("hold_out_c", 32'(ifa.out_c), 32'(ec));
      check("hold_in_ready", 32'(ifa.in_ready), 32'd0);
    end
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    check("after_out_valid", 32'(ifa.out_valid), 32'd0);
    check("after_in_ready", 32'(ifa.in_ready), 32'd1);
  endtask

  task automatic do_op_small(input logic a, input logic b, input logic [2:0] beat);
    int cyc;
    check("s_in_ready", 32'(ifs.in_ready), 32'd1);
    ifs.in_valid = 1'b1; ifs.in_a = a; ifs.in_b = b;
    @(posedge clk); #1;
    ifs.in_valid = 1'b0;
    cyc = 1;
    while (cyc < 40 && !ifs.out_valid) begin
      ifs.rnd_valid = 1'b1; ifs.rnd_data = beat;
      if (cyc == 2) begin
        check("s_port_a", 32'(ifs.port_a), 32'({beat[0], a ^ beat[0]}));
        check("s_port_b", 32'(ifs.port_b), 32'({beat[1], b ^ beat[1]}));
        check("s_port_r", 32'(ifs.port_r), 32'(beat[2]));
      end
      @(posedge clk); #1;
      cyc++;
    end
    ifs.rnd_valid = 1'b0;
    check("s_latency", 32'(cyc), 32'd6);
    check("s_out_c", 32'(ifs.out_c), 32'(a & b));
    ifs.out_ready = 1'b1;
    @(posedge clk); #1;
    ifs.out_ready = 1'b0;
  endtask

  typedef struct {
    logic a; logic b; logic [23:0] beats;
    logic [4:0] pa; logic [4:0] pb; logic [9:0] pr; logic c;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] pa, pb;
    logic [9:0] pr;
    logic a, b;
    logic [23:0] beats;

    tbl[0] = '{1'b1, 1'b1, 24'h0300FF, 5'b11111, 5'b11111, 10'b1100000000, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 24'h000000, 5'b00000, 5'b00001, 10'h000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 24'h000001, 5'b00010, 5'b00000, 10'h000, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 24'h02AB12, 5'b00101, 5'b00011, 10'h2AB, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 24'hFFFFFF, 5'b11111, 5'b11111, 10'h3FF, 1'b1};

    ifa.in_valid = 0; ifa.in_a = 0; ifa.in_b = 0; ifa.rnd_valid = 0; ifa.rnd_data = 0; ifa.out_ready = 0;
    ifs.in_valid = 0; ifs.in_a = 0; ifs.in_b = 0; ifs.rnd_valid = 0; ifs.rnd_data = 0; ifs.out_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_ports", 32'({ifa.port_a, ifa.port_b, ifa.port_r}), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // Abort an operation after one beat; the stale beat must not leak into the next one.
    ifa.in_valid = 1'b1; ifa.in_a = 1'b0; ifa.in_b = 1'b1;
    @(posedge clk); #1;
    ifa.in_valid = 1'b0; ifa.rnd_valid = 1'b1; ifa.rnd_data = 8'h5A;
    @(posedge clk); #1;
    ifa.rnd_valid = 1'b0;
    check("mid_collect_rnd_ready", 32'(ifa.rnd_ready), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(ifa.in_ready), 32'd0);
    check("mid_rst_rnd_ready", 32'(ifa.rnd_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(ifa.in_ready), 32'd1);
    check("abort_out_valid", 32'(ifa.out_valid), 32'd0);
    check("abort_ports", 32'({ifa.port_a, ifa.port_b, ifa.port_r}), 32'd0);

    for (int i = 0; i < 5; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].beats, 8'hFF, 0, tbl[i].pa, tbl[i].pb, tbl[i].pr, tbl[i].c);

    // Source stalls 1-0-0-1-1, then backpressure for 5 cycles followed by an immediate next op.
    do_op(tbl[0].a, tbl[0].b, tbl[0].beats, 8'hF9, 0, tbl[0].pa, tbl[0].pb, tbl[0].pr, tbl[0].c);
    do_op(tbl[3].a, tbl[3].b, tbl[3].beats, 8'hFF, 5, tbl[3].pa, tbl[3].pb, tbl[3].pr, tbl[3].c);
    do_op(tbl[0].a, tbl[0].b, tbl[0].beats, 8'hFF, 0, tbl[0].pa, tbl[0].pb, tbl[0].pr, tbl[0].c);

    for (int p = 0; p < 4; p++) begin
      a = p[1]; b = p[0]; beats = 24'($urandom);
      model(a, b, beats, pa, pb, pr);
      do_op(a, b, beats, 8'hFF, 0, pa, pb, pr, a & b);
    end

    for (int n = 0; n < 12; n++) begin
      a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); beats = 24'($urandom);
      model(a, b, beats, pa, pb, pr);
      do_op(a, b, beats, 8'($urandom), int'($urandom_range(0, 3)), pa, pb, pr, a & b);
    end

    for (int p = 0; p < 8; p++)
      do_op_small(p[1] ^ p[2], p[0], 3'($urandom));

    check("ready_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/isw_share_codec.md
# isw_share_codec

- Harness that masks plain operands into Boolean shares, drives the order-D masked ISW AND gadget, and unmasks the gadget's output shares into a plain result.
- Collects fresh randomness from a valid/ready random source, splits `port_a`/`port_b` into N = D+1 shares, and supplies the gadget's D(D+1)/2 refresh bits.
- Tracks the gadget's fixed 3-cycle pipeline latency, then recombines `port_c` and presents the result on a valid/ready output.

## Interface
Parameters:
- D, 4, masking order; N = D+1 shares
- RW, 8, randomness bits per source beat (1..32)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - reset  in  1  asynchronous active-high reset
- Input handshake and operands:
  - in_valid  in  1  operand pair valid
  - in_ready  out  1  codec can accept operands
  - in_a  in  1  plain operand a
  - in_b  in  1  plain operand b
- Random source:
  - rnd_valid  in  1  random beat valid
  - rnd_ready  out  1  codec consumes a beat
  - rnd_data  in  RW  fresh random bits
- Gadget side:
  - port_a  out  N  shares of a, to gadget
  - port_b  out  N  shares of b, to gadget
  - port_r  out  D(D+1)/2  gadget refresh randomness
  - port_c  in  N  gadget output shares
- Output handshake and result:
  - out_valid  out  1  result valid
  - out_ready  in  1  consumer accepts result
  - out_c  out  1  plain a AND b

## Operation
- Randomness per operation:
  - NR = 2D + D(D+1)/2 bits; 18 for D=4.
  - Beats per operation: NB = ceil(NR/RW); 3 for the defaults.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_a/in_b, clear the bit count, go to COLLECT.
  - COLLECT: rnd_ready=1. Each accepted beat writes rnd_data LSB-first at position `cnt` of an NR-bit buffer; `cnt` advances by RW. Bits beyond NR in the final beat are discarded. On the beat that brings `cnt` ≥ NR, go to ISSUE.
  - ISSUE (1 cycle): port_a/port_b/port_r are registered outputs, loaded on the transition into ISSUE.
    - buf[D-1:0] → a shares 1..D.
    - buf[2D-1:D] → b shares 1..D.
    - buf[NR-1:2D] → port_r, in index order.
    - Share 0 = plain value XOR all other shares of that operand.
  - WAIT (2 cycles): down-counter.
  - CAPTURE (1 cycle): out_c ← XOR of port_c[N-1:0]. On exit, clear port_a, port_b and port_r to 0 (no stale shares held).
  - DONE: out_valid=1; out_c held stable. On out_ready, go to IDLE.
- Flow control:
  - in_ready and rnd_ready are never high simultaneously.
  - in_ready is low in every state except IDLE.
- Reset:
  - All state and outputs are 0 and the FSM is in IDLE.
  - A reset mid-operation aborts it: no out_valid is produced and partial randomness is discarded.

## Timing
- Reset values: in_ready=0 during reset and 1 in the first cycle after it; all other outputs 0.
- Gadget timing:
  - Shares driven in cycle t appear on port_c in cycle t+3.
  - The ISSUE cycle is t; CAPTURE samples in t+3.
- Latency: with rnd_valid held high, an input handshake in cycle 0 gives out_valid in cycle NB+5 (cycle 8 for the defaults).
- Throughput: one operation per NB+6 cycles when out_ready is held high.
- Stalls:
  - rnd_valid low stalls COLLECT indefinitely; the buffer is held.
  - out_ready low holds DONE.
- Simultaneous events: in_valid in DONE is ignored, because in_ready=0.

## Structure
- Shared package `isw_codec_pkg` holds:
  - the state enum;
  - functions N(D), R(D) = D(D+1)/2, NR(D, RW) and NB(D, RW);
  - the 3-cycle gadget latency constant.
- Sub-module `rnd_collector`: RW-to-NR beat accumulator with the `cnt` counter, a `full` flag and `clear`. The FSM, share split and unmasking XOR stay in the top module.

## Test plan
- **Reset and idle outputs:** reset asserted mid-COLLECT (after 1 beat), then released → in_ready=1, out_valid=0, port_a/port_b/port_r=0; the next operation uses only new beats.
- **Concrete encoding, a=1 and b=1:** beats 0xFF, 0x00, 0x03 →
  - port_a=5'b11111, port_b=5'b11111, port_r=10'b1100000000 during ISSUE;
  - out_valid in cycle 8, out_c=1.
- **Exhaustive operands:** all 4 (a, b) pairs with random beats → out_c = a&b. The XOR of port_a equals a during ISSUE.
- **Random-source stalls:** rnd_valid toggled 1-0-0-1-1 → exactly NB beats consumed; out_valid delayed by 2 cycles; same result.
- **Output backpressure:** out_ready low for 5 cycles → out_c stable, in_ready=0 throughout; the next input is accepted the cycle after the out handshake.
- **Parameter sweep:** D=1, RW=3 → NR=3, NB=1; out_valid in cycle 6; correct AND for all operands.
